// File: rtl/seq_gen_param.sv
// Parametrised static-sequence generator: steps a SEQ_W-bit pattern every STEP_DIV clocks
// in one of four shift/rotate modes, stops after STEPS steps and sounds a buzzer.
module seq_gen_param #(
    parameter int SEQ_W    = 8,
    parameter int STEP_DIV = 100000000,
    parameter int STEPS    = 8,
    parameter int BUZZ_CYC = 50000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_valid,
    input  logic [4:0]       key_code,
    input  logic [SEQ_W-1:0] pattern_init,
    output logic [SEQ_W-1:0] led,
    output logic             seq_out,
    output logic             busy,
    output logic             done,
    output logic             buzzer
);

    localparam int DIV_W  = $clog2(STEP_DIV);
    localparam int STEP_W = $clog2(STEPS + 1);
    localparam int BUZZ_W = $clog2(BUZZ_CYC + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(STEP_DIV - 1);
    localparam logic [STEP_W-1:0] STEPS_LAST = STEP_W'(STEPS - 1);
    localparam logic [BUZZ_W-1:0] BUZZ_LAST  = BUZZ_W'(BUZZ_CYC - 1);

    localparam logic [4:0] KEY_LOAD  = 5'd0;
    localparam logic [4:0] KEY_MODE  = 5'd12;
    localparam logic [4:0] KEY_STEP  = 5'd13;
    localparam logic [4:0] KEY_PAUSE = 5'd14;
    localparam logic [4:0] KEY_START = 5'd15;

    typedef enum logic [1:0] {
        M_ROL  = 2'd0,
        M_ROR  = 2'd1,
        M_SHL0 = 2'd2,
        M_SHR0 = 2'd3
    } mode_t;

    // Spare encodings of the 3-bit state fall into the default arm and recover to IDLE.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_PAUSE = 3'd2,
        S_DONE  = 3'd3
    } state_t;

    function automatic logic [SEQ_W-1:0] step_op(input mode_t m, input logic [SEQ_W-1:0] v);
        logic [SEQ_W-1:0] r;
        case (m)
            M_ROL:   r = {v[SEQ_W-2:0], v[SEQ_W-1]};
            M_ROR:   r = {v[0], v[SEQ_W-1:1]};
            M_SHL0:  r = {v[SEQ_W-2:0], 1'b0};
            M_SHR0:  r = {1'b0, v[SEQ_W-1:1]};
            default: r = v;
        endcase
        return r;
    endfunction

    function automatic mode_t next_mode(input mode_t m);
        mode_t r;
        case (m)
            M_ROL:   r = M_ROR;
            M_ROR:   r = M_SHL0;
            M_SHL0:  r = M_SHR0;
            M_SHR0:  r = M_ROL;
            default: r = M_ROL;
        endcase
        return r;
    endfunction

    state_t            state_r;
    mode_t             mode_r;
    logic [DIV_W-1:0]  div_cnt_r;
    logic [STEP_W-1:0] step_cnt_r;
    logic [BUZZ_W-1:0] buzz_cnt_r;

    logic [SEQ_W-1:0]  stepped_s;
    logic              tick_s;
    logic              key_load_s;
    logic              key_mode_s;
    logic              key_step_s;
    logic              key_pause_s;
    logic              key_start_s;

    // Key decode, divider terminal count and the pattern after one step in the current mode.
    always_comb begin
        stepped_s   = step_op(mode_r, led);
        tick_s      = (div_cnt_r == DIV_LAST);
        key_load_s  = key_valid && (key_code == KEY_LOAD);
        key_mode_s  = key_valid && (key_code == KEY_MODE);
        key_step_s  = key_valid && (key_code == KEY_STEP);
        key_pause_s = key_valid && (key_code == KEY_PAUSE);
        key_start_s = key_valid && (key_code == KEY_START);
    end

    // Main FSM; busy/done are updated on the same edge as every state change.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            mode_r     <= M_ROL;
            led        <= pattern_init;
            div_cnt_r  <= {DIV_W{1'b0}};
            step_cnt_r <= {STEP_W{1'b0}};
            buzz_cnt_r <= {BUZZ_W{1'b0}};
            seq_out    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            buzzer     <= 1'b0;
        end else if (key_load_s) begin
            state_r    <= S_IDLE;
            led        <= pattern_init;
            div_cnt_r  <= {DIV_W{1'b0}};
            step_cnt_r <= {STEP_W{1'b0}};
            busy       <= 1'b0;
            done       <= 1'b0;
            buzzer     <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (key_mode_s) begin
                        mode_r <= next_mode(mode_r);
                    end else if (key_step_s) begin
                        led     <= stepped_s;
                        seq_out <= led[SEQ_W-1];
                    end else if (key_start_s) begin
                        state_r    <= S_RUN;
                        div_cnt_r  <= {DIV_W{1'b0}};
                        step_cnt_r <= {STEP_W{1'b0}};
                        busy       <= 1'b1;
                        done       <= 1'b0;
                    end
                end
                S_RUN: begin
                    // A pause on a tick edge discards the tick and leaves div_cnt at its last value.
                    if (key_pause_s) begin
                        state_r <= S_PAUSE;
                    end else if (tick_s) begin
                        div_cnt_r  <= {DIV_W{1'b0}};
                        led        <= stepped_s;
                        seq_out    <= led[SEQ_W-1];
                        step_cnt_r <= step_cnt_r + STEP_W'(1);
                        if (step_cnt_r == STEPS_LAST) begin
                            state_r    <= S_DONE;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            buzz_cnt_r <= {BUZZ_W{1'b0}};
                            buzzer     <= 1'b1;
                        end
                    end else begin
                        div_cnt_r <= div_cnt_r + DIV_W'(1);
                    end
                end
                S_PAUSE: begin
                    if (key_pause_s) begin
                        state_r <= S_RUN;
                    end
                end
                S_DONE: begin
                    if (key_start_s) begin
                        state_r    <= S_RUN;
                        div_cnt_r  <= {DIV_W{1'b0}};
                        step_cnt_r <= {STEP_W{1'b0}};
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        buzzer     <= 1'b0;
                    end else if (buzzer) begin
                        if (buzz_cnt_r == BUZZ_LAST) begin
                            buzzer <= 1'b0;
                        end
                        buzz_cnt_r <= buzz_cnt_r + BUZZ_W'(1);
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    buzzer  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_gen_param.sv
// Bench for seq_gen_param: vector table, directed multi-cycle corner cases and
// randomized keys checked against an arithmetic reference model.
module tb_seq_gen_param;

    localparam int W      = 8;
    localparam int DIV    = 4;
    localparam int NSTEPS = 8;
    localparam int BUZZ   = 3;

    logic         clk;
    logic         rst_n;
    logic         key_valid;
    logic [4:0]   key_code;
    logic [W-1:0] pinit;
    logic [W-1:0] led;
    logic         seq_out;
    logic         busy;
    logic         done;
    logic         buzzer;

    int total = 0;
    int bad   = 0;

    seq_gen_param #(
        .SEQ_W(W), .STEP_DIV(DIV), .STEPS(NSTEPS), .BUZZ_CYC(BUZZ)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
        .pattern_init(pinit), .led(led), .seq_out(seq_out), .busy(busy),
        .done(done), .buzzer(buzzer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: 0 idle, 1 run, 2 pause, 3 done; mode 0 ROL, 1 ROR, 2 SHL0, 3 SHR0.
    int         m_state, m_mode, m_div, m_steps, m_bc;
    logic [7:0] m_led;
    logic       m_seq, m_buzz;

    function automatic logic [7:0] model_op(input int mode, input logic [7:0] v);
        int x;
        x = int'(v);
        case (mode)
            0:       x = (x * 2) % 256 + x / 128;
            1:       x = x / 2 + (x % 2) * 128;
            2:       x = (x * 2) % 256;
            default: x = x / 2;
        endcase
        return 8'(x);
    endfunction

    task automatic model_edge(input logic r, input logic kv, input logic [4:0] kc, input logic [7:0] pi);
        logic [7:0] nxt;
        nxt = model_op(m_mode, m_led);
        if (!r) begin
            m_state = 0; m_mode = 0; m_led = pi; m_steps = 0; m_div = 0;
            m_seq = 1'b0; m_buzz = 1'b0; m_bc = 0;
        end else if (kv && kc == 5'd0) begin
            m_state = 0; m_led = pi; m_steps = 0; m_div = 0; m_buzz = 1'b0;
        end else begin
            case (m_state)
                0: begin
                    if (kv && kc == 5'd12) m_mode = (m_mode + 1) % 4;
                    else if (kv && kc == 5'd13) begin m_seq = m_led[7]; m_led = nxt; end
                    else if (kv && kc == 5'd15) begin m_state = 1; m_div = 0; m_steps = 0; end
                end
                1: begin
                    if (kv && kc == 5'd14) m_state = 2;
                    else if (m_div == DIV - 1) begin
                        m_div = 0; m_seq = m_led[7]; m_led = nxt; m_steps++;
                        if (m_steps == NSTEPS) begin m_state = 3; m_bc = 0; m_buzz = 1'b1; end
                    end else m_div++;
                end
                2: if (kv && kc == 5'd14) m_state = 1;
                3: begin
                    if (kv && kc == 5'd15) begin
                        m_state = 1; m_div = 0; m_steps = 0; m_buzz = 1'b0;
                    end else if (m_buzz) begin
                        if (m_bc == BUZZ - 1) m_buzz = 1'b0;
                        m_bc++;
                    end
                end
                default: m_state = 0;
            endcase
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock edge with the given key; called and returning at a falling edge.
    task automatic step1(input logic kv, input logic [4:0] kc);
        key_valid = kv;
        key_code  = kc;
        @(posedge clk);
        model_edge(rst_n, kv, kc, pinit);
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 5'd16;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step1(1'b0, 5'd16);
    endtask

    typedef struct {
        logic       kv;
        logic [4:0] kc;
        int         wait_n;
        logic [7:0] led;
        logic       busy;
        logic       done;
        logic       buzz;
    } vec_t;

    vec_t tbl[26];

    task automatic set_v(input int i, input logic kv, input logic [4:0] kc, input int w,
                         input logic [7:0] l, input logic b, input logic d, input logic z);
        tbl[i].kv = kv; tbl[i].kc = kc; tbl[i].wait_n = w;
        tbl[i].led = l; tbl[i].busy = b; tbl[i].done = d; tbl[i].buzz = z;
    endtask

    logic [7:0] shl_led[8] = '{8'h70, 8'hE0, 8'hC0, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00};
    logic       shl_seq[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        int r;
        // ROL run from B8, DONE/buzzer window, then idle-only keys.
        set_v(0,  1'b0, 5'd16, 0, 8'hB8, 1'b0, 1'b0, 1'b0);
        set_v(1,  1'b1, 5'd15, 0, 8'hB8, 1'b1, 1'b0, 1'b0);
        set_v(2,  1'b0, 5'd16, 2, 8'hB8, 1'b1, 1'b0, 1'b0);
        set_v(3,  1'b0, 5'd16, 0, 8'h71, 1'b1, 1'b0, 1'b0);
        set_v(4,  1'b0, 5'd16, 3, 8'hE2, 1'b1, 1'b0, 1'b0);
        set_v(5,  1'b0, 5'd16, 3, 8'hC5, 1'b1, 1'b0, 1'b0);
        set_v(6,  1'b0, 5'd16, 3, 8'h8B, 1'b1, 1'b0, 1'b0);
        set_v(7,  1'b0, 5'd16, 3, 8'h17, 1'b1, 1'b0, 1'b0);
        set_v(8,  1'b0, 5'd16, 3, 8'h2E, 1'b1, 1'b0, 1'b0);
        set_v(9,  1'b0, 5'd16, 3, 8'h5C, 1'b1, 1'b0, 1'b0);
        set_v(10, 1'b0, 5'd16, 3, 8'hB8, 1'b0, 1'b1, 1'b1);
        set_v(11, 1'b0, 5'd16, 1, 8'hB8, 1'b0, 1'b1, 1'b1);
        set_v(12, 1'b0, 5'd16, 0, 8'hB8, 1'b0, 1'b1, 1'b0);
        set_v(13, 1'b0, 5'd16, 4, 8'hB8, 1'b0, 1'b1, 1'b0);
        set_v(14, 1'b1, 5'd12, 0, 8'hB8, 1'b0, 1'b1, 1'b0);
        set_v(15, 1'b1, 5'd0,  0, 8'hB8, 1'b0, 1'b0, 1'b0);
        set_v(16, 1'b1, 5'd5,  0, 8'hB8, 1'b0, 1'b0, 1'b0);
        set_v(17, 1'b1, 5'd16, 0, 8'hB8, 1'b0, 1'b0, 1'b0);
        set_v(18, 1'b1, 5'd12, 0, 8'hB8, 1'b0, 1'b0, 1'b0);
        set_v(19, 1'b1, 5'd13, 0, 8'h5C, 1'b0, 1'b0, 1'b0);
        set_v(20, 1'b1, 5'd13, 0, 8'h2E, 1'b0, 1'b0, 1'b0);
        set_v(21, 1'b1, 5'd0,  0, 8'hB8, 1'b0, 1'b0, 1'b0);
        set_v(22, 1'b1, 5'd12, 0, 8'hB8, 1'b0, 1'b0, 1'b0);
        set_v(23, 1'b1, 5'd13, 0, 8'h70, 1'b0, 1'b0, 1'b0);
        set_v(24, 1'b1, 5'd0,  0, 8'hB8, 1'b0, 1'b0, 1'b0);
        set_v(25, 1'b1, 5'd14, 0, 8'hB8, 1'b0, 1'b0, 1'b0);

        rst_n = 1'b0; key_valid = 1'b0; key_code = 5'd16; pinit = 8'hB8;
        @(negedge clk);
        idle(2);
        chk("reset_seq_out", 32'(seq_out), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 26; i++) begin
            step1(tbl[i].kv, tbl[i].kc);
            idle(tbl[i].wait_n);
            chk($sformatf("vec%0d_led", i),  32'(led),    32'(tbl[i].led));
            chk($sformatf("vec%0d_busy", i), 32'(busy),   32'(tbl[i].busy));
            chk($sformatf("vec%0d_done", i), 32'(done),   32'(tbl[i].done));
            chk($sformatf("vec%0d_buzz", i), 32'(buzzer), 32'(tbl[i].buzz));
        end

        // SHL0 run (mode left at SHL0 by the table) down to all-zero with no early stop.
        step1(1'b1, 5'd15);
        idle(3);
        chk("shl_pre_tick_led", 32'(led), 32'h0B8);
        step1(1'b0, 5'd16);
        chk("shl_led0", 32'(led), 32'(shl_led[0]));
        chk("shl_seq0", 32'(seq_out), 32'(shl_seq[0]));
        for (int k = 1; k < 8; k++) begin
            idle(4);
            chk($sformatf("shl_led%0d", k), 32'(led), 32'(shl_led[k]));
            chk($sformatf("shl_seq%0d", k), 32'(seq_out), 32'(shl_seq[k]));
        end
        chk("shl_done", 32'(done), 32'd1);

        // Back to ROL, pause after one step, long hold, resume two cycles before the next step.
        step1(1'b1, 5'd0);
        step1(1'b1, 5'd12);
        step1(1'b1, 5'd12);
        step1(1'b1, 5'd15);
        idle(4);
        chk("pause_first_step", 32'(led), 32'h071);
        idle(2);
        step1(1'b1, 5'd14);
        chk("pause_busy", 32'(busy), 32'd1);
        idle(20);
        chk("pause_hold_led", 32'(led), 32'h071);
        step1(1'b1, 5'd14);
        step1(1'b0, 5'd16);
        chk("resume_plus1_led", 32'(led), 32'h071);
        step1(1'b0, 5'd16);
        chk("resume_plus2_led", 32'(led), 32'h0E2);

        // Pause on a tick edge discards the tick; resume steps on the next RUN edge.
        idle(3);
        step1(1'b1, 5'd14);
        chk("pause_on_tick_led", 32'(led), 32'h0E2);
        step1(1'b1, 5'd14);
        chk("resume_edge_led", 32'(led), 32'h0E2);
        step1(1'b0, 5'd16);
        chk("resume_tick_led", 32'(led), 32'h0C5);

        // LOAD on a tick edge wins: back to IDLE with the initial pattern.
        idle(3);
        step1(1'b1, 5'd0);
        chk("load_tick_led", 32'(led), 32'h0B8);
        chk("load_tick_busy", 32'(busy), 32'd0);
        idle(5);
        chk("load_tick_idle_led", 32'(led), 32'h0B8);

        // Reset while the buzzer is sounding.
        step1(1'b1, 5'd15);
        idle(32);
        chk("rst_pre_buzz", 32'(buzzer), 32'd1);
        chk("rst_pre_done", 32'(done), 32'd1);
        rst_n = 1'b0;
        step1(1'b0, 5'd16);
        rst_n = 1'b1;
        chk("rst_buzz", 32'(buzzer), 32'd0);
        chk("rst_led", 32'(led), 32'h0B8);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Randomized keys, patterns and occasional resets against the reference model.
        for (int c = 0; c < 3000; c++) begin
            logic       kv;
            logic [4:0] kc;
            rst_n = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 49) == 0) pinit = 8'($urandom);
            kv = ($urandom_range(0, 4) == 0);
            r  = $urandom_range(0, 19);
            if (r < 1)       kc = 5'd0;
            else if (r < 5)  kc = 5'd12;
            else if (r < 9)  kc = 5'd13;
            else if (r < 13) kc = 5'd14;
            else if (r < 17) kc = 5'd15;
            else             kc = 5'($urandom_range(0, 16));
            step1(kv, kc);
            chk("rnd_led",    32'(led),     32'(m_led));
            chk("rnd_seq",    32'(seq_out), 32'(m_seq));
            chk("rnd_busy",   32'(busy),    32'(m_state == 1 || m_state == 2));
            chk("rnd_done",   32'(done),    32'(m_state == 3));
            chk("rnd_buzzer", 32'(buzzer),  32'(m_buzz));
        end
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
